freq_meter: RTL and testbench

- Gated frequency counter; the measuring counterpart to the free-running clock dividers in the design.
- Counts rising edges of an asynchronous input over a fixed window of GATE_CYCLES system clocks and reports the total.
- Checks divided clocks (clk190 and similar) and external test signals on the board; the result feeds the seven-segment display path.

---
 rtl/freq_meter.sv | 120 ++++++++++++
 tb/tb_freq_meter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in edges over GATE_CYCLES clocks and reports the total.
// Define FREQ_METER_DUAL_EDGE_EN to count both rising and falling edges.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

    state_t              state_q;
    logic                sync1_q, sync2_q, sync3_q;
    logic                edge_w;
    logic [GATE_W-1:0]   gate_cnt_q;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_q, ovf_d;
    logic                last_w;
    logic [CNT_W-1:0]    count_out_q;
    logic                valid_q, busy_q, overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

`ifdef FREQ_METER_DUAL_EDGE_EN
    assign edge_w = sync2_q ^ sync3_q;
`else
    assign edge_w = sync2_q & ~sync3_q;
`endif

    // Saturating edge count; the final gate cycle's edge is folded into the result.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        if (edge_w) begin
            if (&edge_cnt_q) ovf_d = 1'b1;
            else             edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    assign last_w = (gate_cnt_q == GATE_W'(GATE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            count_out_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= GATE;
                        busy_q     <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        ovf_q      <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt_q <= gate_cnt_q + 1'b1;
                    edge_cnt_q <= edge_cnt_d;
                    ovf_q      <= ovf_d;
                    if (last_w) begin
                        // Result registers load here so they change together with valid.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        count_out_q <= edge_cnt_d;
                        overflow_q  <= ovf_d;
                    end
                end
                DONE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    ovf_q      <= 1'b0;
                    if (cont) begin
                        state_q <= GATE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out = count_out_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: window length, counts, saturation, continuous mode, reset abort.
module tb_freq_meter;
    localparam int GC = 1000;
    localparam int CW = 8;
    localparam int GW = 10;
`ifdef FREQ_METER_DUAL_EDGE_EN
    localparam int EM = 2;
`else
    localparam int EM = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sig_in = 1'b0;
    logic          start = 1'b0;
    logic          cont = 1'b0;
    logic [CW-1:0] count_out;
    logic          valid, busy, overflow;

    int checks = 0;
    int errors = 0;
    int period = 0;
    int phase  = 0;
    int c, b, nv;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(CW), .GATE_W(GW)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .start(start), .cont(cont),
        .count_out(count_out), .valid(valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Square-wave source, changing 2 ns after the edge; period 0 holds it low.
    initial forever begin
        @(posedge clk);
        #2;
        if (period == 0) begin
            sig_in = 1'b0;
            phase  = 0;
        end else begin
            phase  = (phase + 1) % period;
            sig_in = (phase < period / 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = 0;
        while (valid !== 1'b1 && cyc < 3000) begin
            if (busy === 1'b1) bcyc++;
            @(negedge clk);
            cyc++;
        end
        chk("valid_seen", {31'd0, valid}, 32'd1);
    endtask

    task automatic watch(input int n, output int nvalid);
        nvalid = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid === 1'b1) nvalid++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset  = 1'b1;
        period = 10;
        repeat (20) @(negedge clk);

        // Single window, period 10
        pulse_start();
        chk("t2_busy_start", 32'(busy), 1);
        wait_valid(c, b);
        chk("t2_latency", c, 1000);
        chk("t2_busy_cycles", b, 1000);
        chk("t2_count", 32'(count_out), 100 * EM);
        chk("t2_ovf", 32'(overflow), 0);
        @(negedge clk);
        chk("t2_valid_once", 32'(valid), 0);
        chk("t2_idle", 32'(busy), 0);
        chk("t2_hold", 32'(count_out), 100 * EM);

        // No edges; second start while busy is ignored
        period = 0;
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (300) @(negedge clk);
        pulse_start();
        wait_valid(c, b);
        chk("t3_latency", c, 699);
        chk("t3_count", 32'(count_out), 0);
        chk("t3_ovf", 32'(overflow), 0);
        watch(1500, nv);
        chk("t3_one_valid", nv, 0);
        chk("t3_idle", 32'(busy), 0);

        // Saturation, then a clean window
        period = 2;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(c, b);
        chk("t4_sat_count", 32'(count_out), 255);
        chk("t4_sat_ovf", 32'(overflow), 1);
        period = 10;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(c, b);
        chk("t4_count", 32'(count_out), 100 * EM);
        chk("t4_ovf", 32'(overflow), 0);

        // Continuous mode, period 20
        period = 20;
        repeat (20) @(negedge clk);
        cont = 1'b1;
        pulse_start();
        wait_valid(c, b);
        chk("t5_count0", 32'(count_out), 50 * EM);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_pulse_width", 32'(valid), 0);
            chk("t5_rebusy", 32'(busy), 1);
            wait_valid(c, b);
            chk("t5_interval", c + 1, 1001);
            chk("t5_busy_cycles", b, 1000);
            chk("t5_count", 32'(count_out), 50 * EM);
        end
        repeat (400) @(negedge clk);
        cont = 1'b0;
        wait_valid(c, b);
        chk("t5_last_latency", c, 601);
        chk("t5_last_count", 32'(count_out), 50 * EM);
        @(negedge clk);
        chk("t5_idle", 32'(busy), 0);
        watch(1500, nv);
        chk("t5_no_more_valid", nv, 0);

        // Reset mid-window
        period = 10;
        repeat (20) @(negedge clk);
        pulse_start();
        repeat (500) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count", 32'(count_out), 0);
        chk("t6_valid", 32'(valid), 0);
        chk("t6_ovf", 32'(overflow), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        watch(1500, nv);
        chk("t6_no_valid", nv, 0);
        chk("t6_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
